multi_sub_sfr: RTL and testbench

MULTI_SUB_SFR -- requirements
Module: multi_sub_sfr

---
 rtl/sfr_pkg.sv | 16 +
 rtl/sub_sat_unit.sv | 27 ++
 rtl/multi_sub_sfr.sv | 158 +++++++++++++++
 tb/tb_multi_sub_sfr.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/sfr_pkg.sv
// Shared definitions for the multi-channel subtract/divide register block:
// divide FSM state encoding and default geometry.
package sfr_pkg;

  // Divide sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Default channel width and channel count.
  localparam int SFR_SIZE_DEF = 32;
  localparam int SFR_NCH_DEF  = 4;

endpackage : sfr_pkg

// File: rtl/sub_sat_unit.sv
// Single subtractor shared by the sub command and the divide loop.
// Produces a - b and a borrow flag (b > a).
// Build option: MULTI_SUB_SFR_SAT_EN -- when defined, a borrowing
// subtraction clamps the difference to zero instead of wrapping.
module sub_sat_unit #(
  parameter int SIZE = 32
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic [SIZE-1:0] diff,
  output logic            borrow
);

  logic [SIZE:0] wide_diff;

  // Extra MSB of the widened difference is the borrow out.
  always_comb begin
    wide_diff = {1'b0, a} - {1'b0, b};
    borrow    = wide_diff[SIZE];
`ifdef MULTI_SUB_SFR_SAT_EN
    diff = borrow ? '0 : wide_diff[SIZE-1:0];
`else
    diff = wide_diff[SIZE-1:0];
`endif
  end

endmodule : sub_sat_unit

// File: rtl/multi_sub_sfr.sv
// Multi-channel subtractee register file with a repeated-subtraction
// divider. NCH channels of SIZE bits; load, subtract and divide commands
// address one channel each. While a divide is in progress all commands are
// ignored, but channel readback stays live.
// Build option: MULTI_SUB_SFR_SAT_EN (saturating subtract, see sub_sat_unit).
module multi_sub_sfr
  import sfr_pkg::*;
#(
  parameter int SIZE = SFR_SIZE_DEF,
  parameter int NCH  = SFR_NCH_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [$clog2(NCH)-1:0]  ch,
  input  logic                    ld,
  input  logic                    sub,
  input  logic                    div_start,
  input  logic [SIZE-1:0]         D,
  input  logic [SIZE-1:0]         S,
  output logic [SIZE-1:0]         Q,
  output logic                    zero,
  output logic                    borrow,
  output logic [SIZE-1:0]         quot,
  output logic                    busy,
  output logic                    done,
  output logic                    div_err
);

  localparam int CW = $clog2(NCH);

  div_state_t state_reg, state_next;

  logic [SIZE-1:0] chan_reg [NCH];
  logic [CW-1:0]   dch_reg;
  logic [SIZE-1:0] divisor_reg;
  logic [SIZE-1:0] quot_reg;
  logic            div_err_reg;
  logic            borrow_reg, borrow_next;

  // Shared subtractor operands/results.
  logic [CW-1:0]   sel_ch;
  logic [SIZE-1:0] op_a, op_b, unit_diff;
  logic            unit_borrow;

  // Channel write port.
  logic            wr_en;
  logic [CW-1:0]   wr_ch;
  logic [SIZE-1:0] wr_data;
  logic [NCH-1:0]  ch_we;

  logic div_accept;
  logic quot_inc;

  // While dividing, the subtractor works on the latched channel and divisor;
  // otherwise it serves the sub command on the addressed channel.
  always_comb begin
    sel_ch = (state_reg == RUN) ? dch_reg : ch;
    op_a   = chan_reg[sel_ch];
    op_b   = (state_reg == RUN) ? divisor_reg : S;
  end

  sub_sat_unit #(
    .SIZE (SIZE)
  ) u_sub (
    .a      (op_a),
    .b      (op_b),
    .diff   (unit_diff),
    .borrow (unit_borrow)
  );

  // Divide state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state, command arbitration (ld > sub > div_start) and write control.
  always_comb begin
    state_next  = state_reg;
    wr_en       = 1'b0;
    wr_ch       = ch;
    wr_data     = unit_diff;
    borrow_next = 1'b0;
    div_accept  = 1'b0;
    quot_inc    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (ld) begin
          wr_en   = 1'b1;
          wr_data = D;
        end else if (sub) begin
          wr_en       = 1'b1;
          borrow_next = unit_borrow;
        end else if (div_start) begin
          div_accept = 1'b1;
          // A zero divisor would never terminate; finish immediately.
          state_next = (S == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        wr_ch = dch_reg;
        if (!unit_borrow) begin
          wr_en    = 1'b1;
          quot_inc = 1'b1;
        end else begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Per-channel write-enable decode.
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_we
      assign ch_we[gi] = wr_en && (wr_ch == CW'(gi));
    end
  endgenerate

  // Channel storage; unaddressed channels hold.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (!rst_n)        chan_reg[i] <= '0;
      else if (ch_we[i]) chan_reg[i] <= wr_data;
    end
  end

  // Divide bookkeeping and the one-cycle borrow flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dch_reg     <= '0;
      divisor_reg <= '0;
      quot_reg    <= '0;
      div_err_reg <= 1'b0;
      borrow_reg  <= 1'b0;
    end else begin
      borrow_reg <= borrow_next;
      if (div_accept) begin
        dch_reg     <= ch;
        divisor_reg <= S;
        quot_reg    <= '0;
        div_err_reg <= (S == '0);
      end else if (quot_inc) begin
        quot_reg <= quot_reg + 1'b1;
      end
    end
  end

  assign Q       = chan_reg[ch];
  assign zero    = (Q == '0);
  assign borrow  = borrow_reg;
  assign quot    = quot_reg;
  assign div_err = div_err_reg;
  assign busy    = (state_reg != IDLE);
  assign done    = (state_reg == DONE);

endmodule : multi_sub_sfr

// File: tb/tb_multi_sub_sfr.sv
// Directed bench for multi_sub_sfr at SIZE=8, NCH=4.
// Inputs change 1ns after a rising edge; outputs are sampled there too.
module tb_multi_sub_sfr;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] ch;
  logic       ld, sub, div_start;
  logic [7:0] D, S;
  logic [7:0] Q, quot;
  logic       zero, borrow, busy, done, div_err;

  int vec_cnt = 0;
  int err_cnt = 0;

  multi_sub_sfr #(.SIZE(8), .NCH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ch        (ch),
    .ld        (ld),
    .sub       (sub),
    .div_start (div_start),
    .D         (D),
    .S         (S),
    .Q         (Q),
    .zero      (zero),
    .borrow    (borrow),
    .quot      (quot),
    .busy      (busy),
    .done      (done),
    .div_err   (div_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("  ok %s = %0d", tag, got);
    end
  endtask

  task automatic idle_inputs();
    ld = 1'b0; sub = 1'b0; div_start = 1'b0;
  endtask

  task automatic do_ld(input logic [1:0] c, input logic [7:0] d);
    ch = c; D = d; ld = 1'b1;
    tick();
    ld = 1'b0;
  endtask

  task automatic do_sub(input logic [1:0] c, input logic [7:0] s);
    ch = c; S = s; sub = 1'b1;
    tick();
    sub = 1'b0;
  endtask

  task automatic check_q(input string tag, input logic [1:0] c, input logic [7:0] exp);
    ch = c;
    #1;
    check(tag, Q, exp);
  endtask

  int busy_cycles;
  int done_at;
  logic [7:0] exp_wrap;

  initial begin
    rst_n = 1'b0; ch = 2'd0; D = '0; S = '0;
    idle_inputs();
    tick(); tick();
    rst_n = 1'b1;

    // Preload, then reset for one edge.
    do_ld(2'd0, 8'd11);
    do_ld(2'd1, 8'd22);
    do_ld(2'd2, 8'd33);
    do_ld(2'd3, 8'd44);
    check_q("preload_ch2", 2'd2, 8'd33);
    do_sub(2'd0, 8'd12);
    check("borrow_before_reset", {31'd0, borrow}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) check_q($sformatf("reset_q_ch%0d", i), 2'(i), 8'd0);
    check("reset_zero", {31'd0, zero}, 32'd1);
    check("reset_quot", quot, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_borrow", {31'd0, borrow}, 32'd0);

    // Load and subtract twice on ch1.
    do_ld(2'd1, 8'd100);
    do_sub(2'd1, 8'd30);
    check_q("sub1_ch1", 2'd1, 8'd70);
    check("sub1_borrow", {31'd0, borrow}, 32'd0);
    check("sub1_zero", {31'd0, zero}, 32'd0);
    do_sub(2'd1, 8'd30);
    check_q("sub2_ch1", 2'd1, 8'd40);
    check_q("hold_ch0", 2'd0, 8'd0);
    check_q("hold_ch2", 2'd2, 8'd0);
    check_q("hold_ch3", 2'd3, 8'd0);

    // Underflowing subtract on ch2.
`ifdef MULTI_SUB_SFR_SAT_EN
    exp_wrap = 8'd0;
`else
    exp_wrap = 8'd254;
`endif
    do_ld(2'd2, 8'd5);
    do_sub(2'd2, 8'd7);
    check_q("underflow_ch2", 2'd2, exp_wrap);
    check("underflow_borrow", {31'd0, borrow}, 32'd1);
    tick();
    check("borrow_one_cycle", {31'd0, borrow}, 32'd0);

    // ld wins over sub in the same cycle.
    ch = 2'd0; D = 8'd50; S = 8'd1; ld = 1'b1; sub = 1'b1;
    tick();
    idle_inputs();
    check_q("prio_ld_over_sub", 2'd0, 8'd50);

    // Divide 17 / 5 on ch3; an ld to ch0 while busy is ignored.
    do_ld(2'd3, 8'd17);
    ch = 2'd3; S = 8'd5; div_start = 1'b1;
    tick();
    div_start = 1'b0;
    busy_cycles = 0;
    done_at = 0;
    while (busy && busy_cycles < 50) begin
      busy_cycles++;
      if (done) done_at = busy_cycles;
      if (busy_cycles == 2) begin
        ch = 2'd0; D = 8'd9; ld = 1'b1;
      end else begin
        ch = 2'd3; ld = 1'b0;
      end
      tick();
    end
    ld = 1'b0;
    check("div_busy_cycles", busy_cycles, 32'd5);
    check("div_done_at", done_at, 32'd5);
    check("div_quot", quot, 32'd3);
    check_q("div_remainder", 2'd3, 8'd2);
    check_q("busy_ld_ignored", 2'd0, 8'd50);
    check("div_err_clear", {31'd0, div_err}, 32'd0);

    // Divide by zero on ch1 (value 40).
    ch = 2'd1; S = 8'd0; div_start = 1'b1;
    tick();
    div_start = 1'b0;
    check("dz_done", {31'd0, done}, 32'd1);
    check("dz_err", {31'd0, div_err}, 32'd1);
    check("dz_quot", quot, 32'd0);
    tick();
    check("dz_busy_after", {31'd0, busy}, 32'd0);
    check("dz_err_hold", {31'd0, div_err}, 32'd1);
    check_q("dz_ch1_kept", 2'd1, 8'd40);

    // Reset in the middle of 200 / 1 on ch3.
    do_ld(2'd3, 8'd200);
    ch = 2'd3; S = 8'd1; div_start = 1'b1;
    tick();
    div_start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("abort_quot_mid", quot, 32'd10);
    check_q("abort_ch3_mid", 2'd3, 8'd190);
    check("abort_busy_mid", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    tick();
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_quot", quot, 32'd0);
    check_q("abort_ch3", 2'd3, 8'd0);
    check_q("abort_ch1", 2'd1, 8'd0);
    rst_n = 1'b1;

    // First cycle after release accepts commands.
    do_ld(2'd2, 8'd77);
    check_q("post_reset_ld", 2'd2, 8'd77);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  // Global guard against a hung run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule : tb_multi_sub_sfr
